// File: rtl/bo_regfile_sb.sv
// Integer register file (2 async read ports, 1 write port, x0 = 0) with a write-pending scoreboard.
// Optional write-to-read bypass and same-cycle pend clear: define REGFILE_BYPASS_EN.
module bo_regfile_sb #(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    input  logic            issue_en,
    input  logic [AW-1:0]   issue_rd,
    input  logic            issue_rs1_use,
    input  logic            issue_rs2_use,
    output logic            hazard,
    output logic [AW:0]     pend_cnt
);
    localparam int NREG = 1 << AW;

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] pend;
    logic [NREG-1:0] pend_view;
    logic            wr_live;
    logic            do_set;
    logic            set_hit;
    logic            clr_hit;
    logic [AW:0]     pend_cnt_reg;

    assign wr_live = wr_en && (wr_addr != '0);
    assign regs[0] = '0;
    assign pend[0] = 1'b0;

    // Each register owns its data and pend bit; the set is applied last so it wins a same-edge clear.
    generate
        for (genvar gi = 1; gi < NREG; gi++) begin : g_reg
            logic [XLEN-1:0] data_reg;
            logic            pend_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    data_reg <= '0;
                    pend_reg <= 1'b0;
                end else begin
                    if (wr_live && (wr_addr == AW'(gi))) begin
                        data_reg <= wr_data;
                        pend_reg <= 1'b0;
                    end
                    if (do_set && (issue_rd == AW'(gi))) begin
                        pend_reg <= 1'b1;
                    end
                end
            end

            assign regs[gi] = data_reg;
            assign pend[gi] = pend_reg;
        end
    endgenerate

`ifdef REGFILE_BYPASS_EN
    always_comb begin
        pend_view = pend;
        if (wr_live) begin
            pend_view[wr_addr] = 1'b0;
        end
    end

    assign rs1_data = (wr_live && (rs1_addr == wr_addr)) ? wr_data : regs[rs1_addr];
    assign rs2_data = (wr_live && (rs2_addr == wr_addr)) ? wr_data : regs[rs2_addr];
`else
    assign pend_view = pend;
    assign rs1_data  = regs[rs1_addr];
    assign rs2_data  = regs[rs2_addr];
`endif

    assign hazard = issue_en && ((issue_rs1_use && pend_view[rs1_addr]) ||
                                 (issue_rs2_use && pend_view[rs2_addr]) ||
                                 pend_view[issue_rd]);

    assign do_set = issue_en && !hazard && (issue_rd != '0);

    // Count only real bit transitions: a set+clear of one register leaves it pending.
    assign set_hit = do_set && !pend[issue_rd];
    assign clr_hit = wr_live && pend[wr_addr] && !(do_set && (issue_rd == wr_addr));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_cnt_reg <= '0;
        end else begin
            pend_cnt_reg <= pend_cnt_reg + (AW+1)'(set_hit) - (AW+1)'(clr_hit);
        end
    end

    assign pend_cnt = pend_cnt_reg;
endmodule

// File: doc/bo_regfile_sb.md
# bo_regfile_sb

Parametrised integer register file with an integrated write-pending scoreboard for the multi-cycle and pipelined RISC-V cores. It provides two asynchronous read ports and one synchronous write port, with x0 hard-wired to zero and an asynchronous clear of all state. It tracks which destination registers have an issued but not yet written-back result, and flags read-after-write and write-after-write hazards to the issue stage. Write-to-read bypass is optional.

## Interface
Parameters:
- XLEN, 32, data width of each register.
- AW, 5, register address width; NREG = 2**AW registers (x0..x(NREG-1)).

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- rs1_addr  in  AW  read port 1 address.
- rs2_addr  in  AW  read port 2 address.
- rs1_data  out  XLEN  read port 1 data.
- rs2_data  out  XLEN  read port 2 data.
- wr_en  in  1  writeback strobe.
- wr_addr  in  AW  writeback destination.
- wr_data  in  XLEN  writeback data.
- issue_en  in  1  an instruction is issued this cycle.
- issue_rd  in  AW  destination of the issued instruction.
- issue_rs1_use  in  1  the issued instruction reads rs1_addr.
- issue_rs2_use  in  1  the issued instruction reads rs2_addr.
- hazard  out  1  the candidate instruction must stall. Combinational.
- pend_cnt  out  AW+1  number of pending registers. Registered.

## Operation
- Storage: NREG x XLEN registers. x0 is not stored. Reads of address 0 return 0. Writes to address 0 are discarded.
- Write: on a rising edge with wr_en=1 and wr_addr!=0, Register[wr_addr] <= wr_data.
- Read: rs1_data/rs2_data are combinational from rs1_addr/rs2_addr and current state. The bypass rule is in Configuration.
- Scoreboard: one pend bit per register. pend[0] is always 0.
  - Set: on a rising edge with issue_en=1, hazard=0 and issue_rd!=0, pend[issue_rd] <= 1.
  - Clear: on a rising edge with wr_en=1 and wr_addr!=0, pend[wr_addr] <= 0.
  - Set and clear of the same register on the same edge: set wins, so the bit stays 1. The older result lands and the newer one becomes pending.
  - An issue while hazard=1 has no effect on pend.
- hazard is asserted when issue_en=1 and any of the following holds. Bits are evaluated after the same-cycle clear when the bypass is enabled.
  - (issue_rs1_use and pend[rs1_addr])
  - (issue_rs2_use and pend[rs2_addr])
  - pend[issue_rd], the WAW case.
- hazard is 0 whenever issue_en=0.
- pend_cnt equals the population count of pend and is updated on the same edge as pend (+1, -1, or unchanged). Range 0..NREG-1.
- Writeback to a non-pending register is legal: data is written and pend is unchanged.

## Timing
- Reset, asynchronous while rst=1: all registers 0, all pend bits 0, pend_cnt 0. Consequently rs1_data=rs2_data=0 and hazard=0.
- Reset asserted mid-operation discards in-flight pending state immediately, without waiting for a clock edge.
- Write latency: 1 edge; data is visible on read ports in the following cycle. With the bypass, it is visible in the same cycle.
- Scoreboard latency: a set takes effect after 1 edge. An issue in cycle N to rd=5 followed by a reader of x5 in cycle N+1 sees hazard=1.
- No handshake beyond issue_en/hazard. The issue stage holds its instruction while hazard=1.

## Configuration
- REGFILE_BYPASS_EN defined:
  - If wr_en=1, wr_addr!=0 and rsN_addr==wr_addr, then rsN_data=wr_data in the same cycle.
  - The hazard terms for pend[wr_addr] treat the bit as already cleared.
- REGFILE_BYPASS_EN undefined:
  - Reads return the stored value.
  - hazard uses the registered pend bits only.
  - A consumer issued in the writeback cycle stalls 1 extra cycle.

## Test plan
- Reset: write x3=0xDEADBEEF, then assert rst between edges -> rs1_data reads 0 immediately, pend_cnt=0, hazard=0.
- x0: wr_en=1, wr_addr=0, wr_data=0xFFFFFFFF; issue_en=1, issue_rd=0 -> read x0 returns 0, pend_cnt stays 0, hazard=0.
- RAW:
  - Issue rd=7 in cycle 1.
  - Cycle 2: issue with rs1_addr=7, issue_rs1_use=1 -> hazard=1.
  - Cycle 4: wr x7=0x12345678. With REGFILE_BYPASS_EN: hazard=0 and rs1_data=0x12345678 in cycle 4. Without it: hazard=0 in cycle 5.
- WAW and same-edge set/clear:
  - pend[9]=1, then issue rd=9 -> hazard=1.
  - With pend[9]=1, an unrelated issue rd=9 comes from a fresh state where pend[9]=0 and the same edge carries wr x9 -> pend[9]=1 afterwards and pend_cnt increments by 1.
- Count: issue rd=1..31 on consecutive cycles, no writes -> pend_cnt=31. Writeback all 31 -> pend_cnt=0.
- Parameter sweep: XLEN=64, AW=4 -> wr x15=0x0123456789ABCDEF reads back exactly, and pend_cnt saturates at 15.
